// File: rtl/cuadrado_asm_if.sv
// Handshake bundle between the system controller and the shift-add squarer.
// The in_RR/out_ok pair exists only when SQR_VERIFY_EN is defined.
interface cuadrado_asm_if #(parameter int N = 8);
  logic           init;
  logic [N-1:0]   in_R;
  logic [2*N-1:0] out_P;
  logic           busy;
  logic           done;
`ifdef SQR_VERIFY_EN
  logic [2*N-1:0] in_RR;
  logic           out_ok;

  modport master (output init, in_R, in_RR, input out_P, busy, done, out_ok);
  modport slave  (input init, in_R, in_RR, output out_P, busy, done, out_ok);
`else
  modport master (output init, in_R, input out_P, busy, done);
  modport slave  (input init, in_R, output out_P, busy, done);
`endif
endinterface

// File: rtl/cuadrado_asm.sv
// Sequential shift-add squarer: N-bit root in, 2N-bit square out after N falling edges.
// Optional root check against a radicand is enabled by defining SQR_VERIFY_EN.
module cuadrado_asm #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  cuadrado_asm_if.slave  bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e         state_q, state_d;
  logic [2*N-1:0] a_q, a_d;
  logic [2*N-1:0] p_q, p_d;
  logic [N-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2*N-1:0] p_step;

  assign p_step = b_q[0] ? (p_q + a_q) : p_q;

`ifdef SQR_VERIFY_EN
  logic [N-1:0] r_q, r_d;
  logic         ok_q, ok_d;
  logic [2*N:0] lo, hi, rr;

  // One extra bit so P + 2R + 1 cannot wrap at the top of the range.
  assign lo = {1'b0, p_step};
  assign hi = lo + {{N{1'b0}}, r_q, 1'b0} + (2*N+1)'(1);
  assign rr = {1'b0, bus.in_RR};
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SQR_VERIFY_EN
    r_d     = r_q;
    ok_d    = ok_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.init) begin
          a_d     = {{N{1'b0}}, bus.in_R};
          b_d     = bus.in_R;
          p_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
`ifdef SQR_VERIFY_EN
          r_d     = bus.in_R;
          ok_d    = 1'b0;
`endif
        end
      end
      CALC: begin
        p_d   = p_step;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          done_d  = 1'b1;
          state_d = DONE;
`ifdef SQR_VERIFY_EN
          ok_d    = (lo <= rr) && (rr < hi);
`endif
        end else begin
          busy_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The root datapath updates on the falling edge; this block follows it.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SQR_VERIFY_EN
      r_q     <= '0;
      ok_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SQR_VERIFY_EN
      r_q     <= r_d;
      ok_q    <= ok_d;
`endif
    end
  end

  assign bus.out_P = p_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
`ifdef SQR_VERIFY_EN
  assign bus.out_ok = ok_q;
`endif
endmodule

// File: tb/tb_cuadrado_asm.sv
// Scoreboard bench for cuadrado_asm: a cycle-level handshake model pushes expected
// squares on accept; a posedge monitor pops and compares whenever done is seen.
module tb_cuadrado_asm;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cuadrado_asm_if #(.N(N)) bus ();
  cuadrado_asm #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [2*N-1:0] rr_val;
`ifdef SQR_VERIFY_EN
  assign bus.in_RR = rr_val;
`endif

  typedef struct { longint p; bit ok; } exp_t;
  exp_t   exp_q[$];
  int     model_cnt = 0;
  longint last_p = 0;
  bit     last_ok = 1'b0;
  bit     started = 1'b0;
  bit     prev_done = 1'b0;
  int     n_chk = 0;
  int     n_fail = 0;

  function automatic bit root_ok(longint r, longint rr);
    return (r * r <= rr) && ((r + 1) * (r + 1) > rr);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted root is unavailable for N+1 further edges; done shows
  // on the last of those, busy on the ones before it.
  always @(negedge clk) begin
    started <= 1'b1;
    if (!rst_n) begin
      model_cnt <= 0;
      exp_q.delete();
      last_p  <= 0;
      last_ok <= 1'b0;
    end else if (model_cnt > 0) begin
      model_cnt <= model_cnt - 1;
    end else if (bus.init === 1'b1) begin
      exp_t e;
      e.p  = longint'(bus.in_R) * longint'(bus.in_R);
      e.ok = root_ok(longint'(bus.in_R), longint'(rr_val));
      exp_q.push_back(e);
      model_cnt <= N + 1;
      last_ok   <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (started) begin
      chk("busy", 64'(bus.busy), 64'(model_cnt >= 2));
      chk("done", 64'(bus.done), 64'(model_cnt == 1));
      chk("done_width", 64'(bus.done & prev_done), 64'(0));
      prev_done <= bus.done;
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_unexpected: got done=1 expected no pending result at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_P", 64'(bus.out_P), 64'(e.p));
`ifdef SQR_VERIFY_EN
          chk("out_ok", 64'(bus.out_ok), 64'(e.ok));
`endif
          last_p  <= e.p;
          last_ok <= e.ok;
        end
      end else if (model_cnt == 0) begin
        chk("out_P_hold", 64'(bus.out_P), 64'(last_p));
`ifdef SQR_VERIFY_EN
        chk("out_ok_hold", 64'(bus.out_ok), 64'(last_ok));
`endif
      end else begin
`ifdef SQR_VERIFY_EN
        chk("out_ok_calc", 64'(bus.out_ok), 64'(0));
`endif
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One accepted operation, then enough cycles for the next init to land in IDLE.
  task automatic op(int r, longint rr, bit noise = 1'b0);
    bus.init  = 1'b1;
    bus.in_R  = N'(r);
    rr_val    = (2*N)'(rr);
    cyc();
    for (int i = 0; i < N + 1; i++) begin
      bus.init = noise ? 1'($urandom) : 1'b0;
      bus.in_R = N'($urandom);
      cyc();
    end
    bus.init = 1'b0;
  endtask

  initial begin
    bus.init = 1'b0;
    bus.in_R = '0;
    rr_val   = '0;
    rst_n    = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    op(13, 169);
    cyc(20);
    op(0, 0);
    op(255, 65025);

    // Second init lands on CALC cycle 3 and must be dropped.
    bus.init = 1'b1; bus.in_R = 8'd100; cyc();
    bus.init = 1'b0; cyc(2);
    bus.init = 1'b1; bus.in_R = 8'd200; cyc();
    bus.init = 1'b0; cyc(N - 2);
    cyc(2);

    // Init held high: back-to-back operations every N+2 cycles.
    rr_val = 16'd1000;
    bus.init = 1'b1;
    repeat (35) begin
      bus.in_R = N'($urandom);
      cyc();
    end
    bus.init = 1'b0;
    cyc(N + 2);

    // Reset on CALC cycle 5 aborts, and wins over a simultaneous init.
    bus.init = 1'b1; bus.in_R = 8'd99; cyc();
    bus.init = 1'b0; cyc(4);
    rst_n = 1'b0; bus.init = 1'b1; cyc();
    rst_n = 1'b1; bus.init = 1'b0; cyc(2);
    op(7, 49);

    op(17, 300);
    op(16, 300);
    op(17, 324);
    op(255, 65535);
    op(255, 65024);

    for (int r = 0; r < 256; r++)
      op(r, longint'(r) * r + longint'($urandom_range(0, 2 * r + 1)));

    repeat (40) begin
      int r;
      r = $urandom_range(0, 255);
      op(r, longint'(r) * r + longint'($urandom_range(0, 2 * r + 2)) - 1, 1'b1);
      cyc($urandom_range(0, 3));
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
    end
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
